nios_fft_out_fifo: RTL and testbench

//  Avalon-MM write-side PIO: the Nios pushes 32-bit words to FPGA logic (FFT control/coeff path).

---
 rtl/nios_fft_out_fifo.sv | 119 +++++++++++
 tb/tb_nios_fft_out_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nios_fft_out_fifo.sv
// Avalon-MM write-side PIO: Nios pushes words into a FIFO that drains over a
// valid/ready stream. STATUS, CONTROL and PEEK are readable through a
// registered readdata path with no read side effects.
module nios_fft_out_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_PEEK    = 2'd3
  } reg_sel_t;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               hold;

  logic               wr_cycle;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               flush;
  logic               ovf_clear;
  logic               empty;
  logic               full;
  logic [DATA_W-1:0]  status_word;
  logic [DATA_W-1:0]  control_word;
  reg_sel_t           sel;

  assign sel       = reg_sel_t'(address);
  assign wr_cycle  = chipselect & ~write_n;
  assign empty     = (level == '0);
  assign full      = (level == LEVEL_W'(FIFO_DEPTH));
  assign push_req  = wr_cycle && (sel == REG_DATA);
  assign push      = push_req & ~full;
  assign flush     = wr_cycle && (sel == REG_CONTROL) && writedata[0];
  assign ovf_clear = wr_cycle && (sel == REG_STATUS) && writedata[18];
  assign out_valid = ~empty & ~hold;
  assign pop       = out_valid & out_ready;
  assign out_port  = empty ? '0 : mem[rd_ptr];

  // Assemble the STATUS and CONTROL read views; unmapped bits read 0
  always_comb begin
    status_word                = '0;
    status_word[LEVEL_W-1:0]   = level;
    status_word[16]            = empty;
    status_word[17]            = full;
    status_word[18]            = overflow;
    control_word               = '0;
    control_word[1]            = hold;
  end

  // FIFO storage; contents are don't-care while not counted by level
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

  // Pointers, level, sticky overflow and hold control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      hold     <= 1'b0;
    end else begin
      // Flush overrides any push or pop in the same cycle
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      level <= level + LEVEL_W'(1);
        else if (pop && !push) level <= level - LEVEL_W'(1);
      end
      // Setting wins over a same-cycle W1C clear
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clear)   overflow <= 1'b0;
      if (wr_cycle && (sel == REG_CONTROL)) hold <= writedata[1];
    end
  end

  // Registered read mux, sampled every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      unique case (sel)
        REG_DATA:    readdata <= '0;
        REG_STATUS:  readdata <= status_word;
        REG_CONTROL: readdata <= control_word;
        REG_PEEK:    readdata <= out_port;
        default:     readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_fft_out_fifo.sv
// Directed bench for nios_fft_out_fifo; inputs driven and outputs sampled on
// the falling clock edge.
module tb_nios_fft_out_fifo;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_valid;
  logic        out_ready;

  int unsigned passed;
  int unsigned total;

  nios_fft_out_fifo #(.DATA_W(32), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One write cycle; returns on the falling edge after the write edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] r;

  initial begin
    passed     = 0;
    total      = 0;
    reset_n    = 1'b0;
    address    = 2'd1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_port", out_port, 32'd0);
    reset_n = 1'b1;

    // 1: status after reset
    rd(2'd1, r);
    check("t1_status", r, 32'h0001_0000);

    // 2: three writes then ordered drain
    for (int i = 1; i <= 3; i++) wr(2'd0, 32'hA5A5_0000 + 32'(i));
    rd(2'd1, r);
    check("t2_level", r, 32'h0000_0003);
    check("t2_port", out_port, 32'hA5A5_0001);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    rd(2'd3, r);
    check("t2_peek", r, 32'hA5A5_0001);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("t2_drain", out_port, 32'hA5A5_0000 + 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("t2_empty_valid", {31'd0, out_valid}, 32'd0);
    check("t2_empty_port", out_port, 32'd0);
    rd(2'd1, r);
    check("t2_status", r, 32'h0001_0000);

    // 3: fill, overflow, W1C clear, drain without the dropped word
    for (int i = 0; i < 16; i++) wr(2'd0, 32'h1000_0000 + 32'(i));
    wr(2'd0, 32'hDEAD_BEEF);
    rd(2'd1, r);
    check("t3_full_ovf", r, 32'h0006_0010);
    check("t3_head", out_port, 32'h1000_0000);
    wr(2'd1, 32'h0004_0000);
    rd(2'd1, r);
    check("t3_ovf_clr", r, 32'h0002_0010);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain", out_port, 32'h1000_0000 + 32'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    rd(2'd1, r);
    check("t3_status", r, 32'h0001_0000);

    // 4: hold blocks popping but not pushing
    wr(2'd2, 32'h0000_0002);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h2000_0000 + 32'(i));
    check("t4_hold_valid", {31'd0, out_valid}, 32'd0);
    rd(2'd1, r);
    check("t4_level", r, 32'h0000_0004);
    rd(2'd2, r);
    check("t4_ctrl", r, 32'h0000_0002);
    wr(2'd2, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", out_port, 32'h2000_0000 + 32'(i));
      @(negedge clk);
    end
    check("t4_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 5: flush with 5 words and overflow set, coinciding with a pop
    for (int i = 0; i < 16; i++) wr(2'd0, 32'h3000_0000 + 32'(i));
    wr(2'd0, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    repeat (11) @(negedge clk);
    out_ready = 1'b0;
    check("t5_head", out_port, 32'h3000_000B);
    rd(2'd1, r);
    check("t5_pre", r, 32'h0004_0005);
    out_ready = 1'b1;
    wr(2'd2, 32'h0000_0001);
    out_ready = 1'b0;
    rd(2'd1, r);
    check("t5_flushed", r, 32'h0005_0000);
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    rd(2'd2, r);
    check("t5_ctrl", r, 32'h0000_0000);
    wr(2'd1, 32'h0004_0000);

    // 7: push to empty with ready (no same-cycle pop), then push+pop together
    out_ready = 1'b1;
    wr(2'd0, 32'h4000_0001);
    check("t7_first", out_port, 32'h4000_0001);
    check("t7_first_v", {31'd0, out_valid}, 32'd1);
    wr(2'd0, 32'h4000_0002);
    check("t7_pushpop", out_port, 32'h4000_0002);
    out_ready = 1'b0;
    rd(2'd1, r);
    check("t7_level", r, 32'h0000_0001);

    // 6: asynchronous reset in the middle of a drain
    wr(2'd0, 32'h5000_0001);
    wr(2'd0, 32'h5000_0002);
    address   = 2'd1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rdata", readdata, 32'd0);
    check("t6_port", out_port, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b0;
    rd(2'd1, r);
    check("t6_status", r, 32'h0001_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
